// File: rtl/cache_rd_arbiter.sv
// Arbitrates icache/dcache reads onto one bridge read port, one read outstanding, with write-line hazard hold-off.
// Grant in IDLE is combinational (rd_rdy); mem_rd_req follows one cycle later and holds until mem_rd_rdy.
module cache_rd_arbiter #(
  parameter int STARVE_LIMIT     = 4,
  parameter int LINE_OFFSET_BITS = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        icache_rd_req,
  input  logic [2:0]  icache_rd_type,
  input  logic [31:0] icache_rd_addr,
  output logic        icache_rd_rdy,
  output logic        icache_ret_valid,
  output logic        icache_ret_last,
  output logic [31:0] icache_ret_data,
  input  logic        dcache_rd_req,
  input  logic [2:0]  dcache_rd_type,
  input  logic [31:0] dcache_rd_addr,
  output logic        dcache_rd_rdy,
  output logic        dcache_ret_valid,
  output logic        dcache_ret_last,
  output logic [31:0] dcache_ret_data,
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  output logic        mem_rd_req,
  output logic [2:0]  mem_rd_type,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic        mem_ret_valid,
  input  logic        mem_ret_last,
  input  logic [31:0] mem_ret_data
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RESP = 3'b100
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  type_q, type_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic i_blk, d_blk, i_elig, d_elig, i_win, d_win;

  // Line compare done on shifted full words so the offset bits drop out.
  assign i_blk  = wr_pending && ((icache_rd_addr >> LINE_OFFSET_BITS) == (wr_addr >> LINE_OFFSET_BITS));
  assign d_blk  = wr_pending && ((dcache_rd_addr >> LINE_OFFSET_BITS) == (wr_addr >> LINE_OFFSET_BITS));
  assign i_elig = icache_rd_req && !i_blk;
  assign d_elig = dcache_rd_req && !d_blk;
  assign i_win  = i_elig && (!d_elig || (starve_cnt_q == LIMIT));
  assign d_win  = d_elig && !i_win;

  assign mem_rd_addr = addr_q;
  assign mem_rd_type = type_q;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    type_d           = type_q;
    starve_cnt_d     = starve_cnt_q;
    icache_rd_rdy    = 1'b0;
    dcache_rd_rdy    = 1'b0;
    mem_rd_req       = 1'b0;
    icache_ret_valid = 1'b0;
    icache_ret_last  = 1'b0;
    dcache_ret_valid = 1'b0;
    dcache_ret_last  = 1'b0;
    icache_ret_data  = areset ? 32'h0 : mem_ret_data;
    dcache_ret_data  = areset ? 32'h0 : mem_ret_data;
    case (state_q)
      IDLE: begin
        if (!areset && (i_win || d_win)) begin
          icache_rd_rdy = i_win;
          dcache_rd_rdy = d_win;
          owner_d       = d_win;
          addr_d        = d_win ? dcache_rd_addr : icache_rd_addr;
          type_d        = d_win ? dcache_rd_type : icache_rd_type;
          state_d       = REQ;
          if (i_win) begin
            starve_cnt_d = 4'd0;
          end else if (i_elig && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_rdy) begin
          state_d = RESP;
        end
      end
      RESP: begin
        icache_ret_valid = !owner_q && mem_ret_valid;
        icache_ret_last  = !owner_q && mem_ret_valid && mem_ret_last;
        dcache_ret_valid = owner_q && mem_ret_valid;
        dcache_ret_last  = owner_q && mem_ret_valid && mem_ret_last;
        if (mem_ret_valid && mem_ret_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= 32'h0;
      type_q       <= 3'b000;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: arbitration vector table, bridge model with beat scoreboard, hand-written corner sequences.
module tb_cache_rd_arbiter;

  logic        aclk, areset;
  logic        icache_rd_req, dcache_rd_req;
  logic [2:0]  icache_rd_type, dcache_rd_type;
  logic [31:0] icache_rd_addr, dcache_rd_addr;
  logic        icache_rd_rdy, icache_ret_valid, icache_ret_last;
  logic        dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
  logic [31:0] icache_ret_data, dcache_ret_data;
  logic        wr_pending;
  logic [31:0] wr_addr;
  logic        mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [2:0]  mem_rd_type;
  logic [31:0] mem_rd_addr, mem_ret_data;

  cache_rd_arbiter #(.STARVE_LIMIT(4), .LINE_OFFSET_BITS(4)) dut (
    .aclk(aclk), .areset(areset),
    .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
    .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type), .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
    .dcache_ret_data(dcache_ret_data),
    .wr_pending(wr_pending), .wr_addr(wr_addr),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic        who;
    logic [31:0] dat;
    logic        last;
  } beat_t;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        wp;
    logic [31:0] wa;
    logic        ei;
    logic        ed;
  } vec_t;

  beat_t       beat_q[$];
  bit          grant_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          xact_open = 0;
  bit          stale = 0;
  logic        exp_owner = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [2:0]  exp_type = 3'b000;
  int          grant_cyc = 0;
  int          rdy_delay = 1;
  logic [31:0] data_base = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    $display("FAIL %s: DUT event did not arrive within the cycle budget (t=%0t)", nm, $time);
  endtask

  task automatic chk_all_zero(input string nm);
    check({nm, "_ctl"}, 32'({icache_rd_rdy, dcache_rd_rdy, mem_rd_req, icache_ret_valid, icache_ret_last,
                             dcache_ret_valid, dcache_ret_last}), 32'h0);
    check({nm, "_addr"}, mem_rd_addr, 32'h0);
    check({nm, "_type"}, 32'(mem_rd_type), 32'h0);
    check({nm, "_idat"}, icache_ret_data, 32'h0);
    check({nm, "_ddat"}, dcache_ret_data, 32'h0);
  endtask

  task automatic wait_grant(input bit who);
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge aclk);
      if (who ? dcache_rd_rdy : icache_rd_rdy) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_to(who ? "grant_d_wait" : "grant_i_wait");
  endtask

  task automatic wait_xact();
    bit done = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge aclk);
      #2;
      if (!xact_open) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_to("xact_done_wait");
  endtask

  // Scoreboard: grants and return beats compared against what the bench queued.
  initial begin
    beat_t b;
    bit    w;
    forever begin
      @(negedge aclk);
      if (areset) begin
        stale     = 1;
        xact_open = 0;
      end
      if (stale) beat_q.delete();
      if (icache_rd_rdy || dcache_rd_rdy) begin
        if (grant_q.size() == 0 || xact_open) begin
          check("unexpected_grant", 32'({icache_rd_rdy, dcache_rd_rdy}), 32'h0);
        end else begin
          w = grant_q.pop_front();
          check("grant_who", 32'({icache_rd_rdy, dcache_rd_rdy}), w ? 32'd1 : 32'd2);
          exp_owner = w;
          exp_addr  = w ? dcache_rd_addr : icache_rd_addr;
          exp_type  = w ? dcache_rd_type : icache_rd_type;
          grant_cyc = cyc;
          xact_open = 1;
          stale     = 0;
        end
      end
      if (icache_ret_valid || dcache_ret_valid || icache_ret_last || dcache_ret_last) begin
        if (beat_q.size() == 0) begin
          check("unexpected_ret", 32'({icache_ret_valid, dcache_ret_valid, icache_ret_last, dcache_ret_last}), 32'h0);
        end else begin
          b = beat_q.pop_front();
          check("ret_vld", 32'({icache_ret_valid, dcache_ret_valid}), b.who ? 32'd1 : 32'd2);
          check("ret_last", 32'({icache_ret_last, dcache_ret_last}), b.last ? (b.who ? 32'd1 : 32'd2) : 32'd0);
          check("ret_idat", icache_ret_data, b.dat);
          check("ret_ddat", dcache_ret_data, b.dat);
          if (b.last) xact_open = 0;
        end
      end
    end
  end

  // Bridge model: accepts after rdy_delay stall cycles, returns 4 beats for line reads, 1 otherwise.
  initial begin
    int nb;
    mem_rd_rdy    = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_ret_data  = 32'h0;
    forever begin
      @(posedge aclk);
      #1;
      if (mem_rd_req) begin
        check("req_latency", 32'(cyc - grant_cyc), 32'd1);
        for (int k = 0; k <= rdy_delay; k++) begin
          if (k > 0) begin
            @(posedge aclk);
            #1;
          end
          check("req_hold", 32'(mem_rd_req), 32'd1);
          check("req_addr", mem_rd_addr, exp_addr);
          check("req_type", 32'(mem_rd_type), 32'(exp_type));
          if (k == rdy_delay) mem_rd_rdy = 1'b1;
        end
        @(posedge aclk);
        #1;
        mem_rd_rdy = 1'b0;
        check("req_drop", 32'(mem_rd_req), 32'd0);
        nb = exp_type[2] ? 4 : 1;
        for (int b = 0; b < nb; b++) begin
          mem_ret_valid = 1'b1;
          mem_ret_last  = (b == nb - 1);
          mem_ret_data  = data_base + 32'(b);
          beat_q.push_back('{exp_owner, data_base + 32'(b), (b == nb - 1)});
          @(posedge aclk);
          #1;
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        mem_ret_data  = 32'h0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h1C00_0040, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_3000, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_300C, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3000, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_3010, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_4020, 1'b1, 32'h0000_400F, 1'b1, 32'h0000_4000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_400C, 1'b1, 32'h0000_4010, 1'b1, 32'h0000_4000, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_4004, 1'b1, 32'h0000_4008, 1'b1, 32'h0000_4000, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_4004, 1'b1, 32'h0000_4008, 1'b0, 32'h0000_4000, 1'b0, 1'b1};

    areset         = 1'b1;
    icache_rd_req  = 1'b1;
    icache_rd_type = 3'b100;
    icache_rd_addr = 32'h0;
    dcache_rd_req  = 1'b0;
    dcache_rd_type = 3'b010;
    dcache_rd_addr = 32'h0;
    wr_pending     = 1'b0;
    wr_addr        = 32'h0;
    @(negedge aclk);
    chk_all_zero("reset");
    icache_rd_req = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    // Arbitration table, each applied from IDLE.
    for (int v = 0; v < 10; v++) begin
      @(posedge aclk);
      #1;
      data_base      = 32'hD000_0000 + 32'(v << 8);
      icache_rd_req  = vecs[v].i_req;
      icache_rd_addr = vecs[v].i_addr;
      dcache_rd_req  = vecs[v].d_req;
      dcache_rd_addr = vecs[v].d_addr;
      wr_pending     = vecs[v].wp;
      wr_addr        = vecs[v].wa;
      if (vecs[v].ei) grant_q.push_back(1'b0);
      if (vecs[v].ed) grant_q.push_back(1'b1);
      @(negedge aclk);
      check($sformatf("vec%0d_rdy", v), 32'({icache_rd_rdy, dcache_rd_rdy}), 32'({vecs[v].ei, vecs[v].ed}));
      @(posedge aclk);
      #1;
      icache_rd_req = 1'b0;
      dcache_rd_req = 1'b0;
      wr_pending    = 1'b0;
      if (vecs[v].ei || vecs[v].ed) wait_xact();
    end

    // Bridge backpressure: 5 stall cycles, icache keeps asking meanwhile.
    @(posedge aclk);
    #1;
    rdy_delay      = 5;
    data_base      = 32'hB000_0000;
    icache_rd_addr = 32'h0000_8000;
    dcache_rd_addr = 32'h0000_9000;
    icache_rd_req  = 1'b1;
    dcache_rd_req  = 1'b1;
    grant_q.push_back(1'b1);
    wait_grant(1'b1);
    @(posedge aclk);
    #1 dcache_rd_req = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      check("bp_no_second_grant", 32'({icache_rd_rdy, dcache_rd_rdy}), 32'h0);
    end
    @(posedge aclk);
    #1 icache_rd_req = 1'b0;
    wait_xact();
    rdy_delay = 1;

    // Write hazard: dcache line matches pending write, icache goes first.
    @(posedge aclk);
    #1;
    data_base      = 32'hC000_0000;
    wr_pending     = 1'b1;
    wr_addr        = 32'h0000_1008;
    dcache_rd_addr = 32'h0000_1000;
    icache_rd_addr = 32'h0000_2000;
    icache_rd_req  = 1'b1;
    dcache_rd_req  = 1'b1;
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    wait_grant(1'b0);
    @(posedge aclk);
    #1 icache_rd_req = 1'b0;
    wait_xact();
    repeat (3) begin
      @(negedge aclk);
      check("hazard_block", 32'(dcache_rd_rdy), 32'd0);
    end
    @(posedge aclk);
    #1 wr_pending = 1'b0;
    @(negedge aclk);
    check("hazard_release", 32'(dcache_rd_rdy), 32'd1);
    @(posedge aclk);
    #1 dcache_rd_req = 1'b0;
    wait_xact();

    // Starvation: both eligible throughout, icache every fifth grant.
    @(posedge aclk);
    #1;
    rdy_delay      = 0;
    data_base      = 32'h5A00_0000;
    icache_rd_addr = 32'h0000_6000;
    dcache_rd_addr = 32'h0000_7000;
    icache_rd_req  = 1'b1;
    dcache_rd_req  = 1'b1;
    for (int g = 0; g < 10; g++) grant_q.push_back((g % 5) != 4);
    for (int g = 0; g < 10; g++) begin
      wait_grant((g % 5) != 4);
      if ((g % 5) == 4) begin
        @(posedge aclk);
        #1;
        check($sformatf("starve_clr%0d", g), 32'(dut.starve_cnt_q), 32'd0);
      end
    end
    icache_rd_req = 1'b0;
    dcache_rd_req = 1'b0;
    wait_xact();

    // Uncached single-beat dcache read, then regrant on the very next cycle.
    @(posedge aclk);
    #1;
    rdy_delay      = 1;
    data_base      = 32'hDEAD_BEEF;
    dcache_rd_addr = 32'h0000_A000;
    dcache_rd_req  = 1'b1;
    grant_q.push_back(1'b1);
    wait_grant(1'b1);
    @(posedge aclk);
    #1 dcache_rd_req = 1'b0;
    wait_xact();
    data_base      = 32'h1111_0000;
    icache_rd_addr = 32'h0000_B000;
    icache_rd_req  = 1'b1;
    grant_q.push_back(1'b0);
    @(negedge aclk);
    check("idle_regrant", 32'(icache_rd_rdy), 32'd1);
    @(posedge aclk);
    #1 icache_rd_req = 1'b0;
    wait_xact();

    // Reset after two of four beats; later beats must be dropped.
    @(posedge aclk);
    #1;
    rdy_delay      = 0;
    data_base      = 32'h5000_0000;
    icache_rd_addr = 32'h0000_5000;
    icache_rd_req  = 1'b1;
    grant_q.push_back(1'b0);
    wait_grant(1'b0);
    @(posedge aclk);
    #1 icache_rd_req = 1'b0;
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    areset         = 1'b1;
    dcache_rd_addr = 32'h0000_C000;
    dcache_rd_req  = 1'b1;
    @(negedge aclk);
    chk_all_zero("rst_mid");
    @(posedge aclk);
    #1;
    areset        = 1'b0;
    dcache_rd_req = 1'b0;
    @(negedge aclk);
    check("stale_beat", 32'({icache_ret_valid, icache_ret_last, dcache_ret_valid, dcache_ret_last}), 32'h0);
    @(posedge aclk);
    #1;
    data_base     = 32'h7700_0000;
    dcache_rd_req = 1'b1;
    grant_q.push_back(1'b1);
    wait_grant(1'b1);
    @(posedge aclk);
    #1 dcache_rd_req = 1'b0;
    wait_xact();

    repeat (3) @(posedge aclk);
    check("grants_left", 32'(grant_q.size()), 32'd0);
    check("beats_left", 32'(beat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
